// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and helpers for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W + 1);

  // Operands are sign-extended to 64 bits first, so the most negative W-bit
  // value comes back as its true unsigned magnitude in the low W bits.
  function automatic logic [63:0] abs_w(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division step
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   p,
  input  logic [W-1:0] q,
  input  logic [W-1:0] d,
  output logic [W:0]   p_next,
  output logic [W-1:0] q_next
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       ge;

  // p[W] set means the shifted value already exceeds any W-bit divisor.
  assign shifted = {p[W-1:0], q[W-1]};
  assign ge      = p[W] | (shifted >= {1'b0, d});
  assign diff    = shifted - {1'b0, d};
  assign p_next  = ge ? diff : shifted;
  assign q_next  = {q[W-2:0], ge};

endmodule

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - multi-cycle signed restoring divider with start/done handshake
module sequential_divider
  import div_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W:0]    p_reg;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  d_reg;
  logic          sign_a;
  logic          sign_b;

  logic [63:0]   abs_a64;
  logic [63:0]   abs_b64;
  logic [W-1:0]  abs_a;
  logic [W-1:0]  abs_b;
  logic          unused_abs_hi;
  logic [W:0]    p_next;
  logic [W-1:0]  q_next;
  logic          accept;

  assign abs_a64       = abs_w(64'(signed'(a)));
  assign abs_b64       = abs_w(64'(signed'(b)));
  assign abs_a         = abs_a64[W-1:0];
  assign abs_b         = abs_b64[W-1:0];
  assign unused_abs_hi = ^{abs_a64[63:W], abs_b64[63:W]};

  assign accept = start && (state == ST_IDLE || state == ST_DONE);

  div_step #(.W(W)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .d      (d_reg),
    .p_next (p_next),
    .q_next (q_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      p_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            sign_a <= a[W-1];
            sign_b <= b[W-1];
            p_reg  <= '0;
            q_reg  <= abs_a;
            d_reg  <= abs_b;
            cnt    <= CW'(W);
            if (b == '0) begin
              // Zero divisor resolves on the accepting edge without iterating.
              quotient    <= '1;
              remainder   <= a;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= ST_DONE;
            end else begin
              div_by_zero <= 1'b0;
              done        <= 1'b0;
              busy        <= 1'b1;
              state       <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          p_reg <= p_next;
          q_reg <= q_next;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quotient    <= (sign_a ^ sign_b) ? (W'(0) - q_reg) : q_reg;
          remainder   <= sign_a ? (W'(0) - p_reg[W-1:0]) : p_reg[W-1:0];
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= 1'b0;
          state       <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Multi-cycle signed integer divider, the inverse of sequential_multiplier. It shares that block's start/done handshake and operand conventions.
- Radix-2 restoring division on operand magnitudes, then a sign fix-up.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.
- Sits beside the multipliers in the arithmetic datapath; the same bench harness drives it.

Parameters:
W, 32, operand width in bits; quotient and remainder are also W bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only while idle or done
a  input  W  signed dividend; sampled on the accepting edge
b  input  W  signed divisor; sampled on the accepting edge
quotient  output  W  signed quotient, registered
remainder  output  W  signed remainder, registered
done  output  1  result valid; held until the next accepted start
busy  output  1  high while a division is in progress
div_by_zero  output  1  the last result came from b == 0; valid with done

Behaviour:
- Reset (async assert, sync release): state IDLE; quotient, remainder, done, busy and div_by_zero all 0; working registers cleared. Reset mid-operation aborts with no result.
- States: IDLE, ITER, FIX, DONE.
- Accept: start = 1 in IDLE or DONE at edge k.
  - Operands are captured and done is cleared.
  - Sign flags, |a| and |b| are computed in W bits. The magnitude of -2^(W-1) is 2^(W-1) as an unsigned value.
  - Iteration counter loads W.
  - If b != 0: go to ITER; busy = 1 from edge k.
  - If b == 0: go straight to DONE.
- start in ITER or FIX is ignored, with no effect on state or operands.
- Divide by zero, at edge k:
  - quotient = all ones (-1), remainder = a, div_by_zero = 1, done = 1.
  - Latency 1 cycle; busy never asserts.
- ITER, one restoring step per edge, edges k+1 .. k+W:
  - Partial remainder P is W+1 bits; P = {P, msb of Q}.
  - If P >= |b|: P -= |b| and shift 1 into Q; otherwise shift 0.
  - Counter decrements; the last step moves to FIX.
- FIX, edge k+W+1:
  - quotient = (sign_a XOR sign_b) ? -Q : Q.
  - remainder = sign_a ? -P[W-1:0] : P[W-1:0].
  - done = 1, busy = 0, div_by_zero = 0; go to DONE.
  - Total latency: W+1 edges after the accepting edge.
- Overflow: a = -2^(W-1), b = -1 gives quotient = -2^(W-1) (wraps), remainder 0, no flag.
- quotient and remainder hold the previous result during computation. They change only at FIX or at a divide-by-zero accept.
- DONE holds all outputs stable until start or reset. Start in DONE behaves exactly as start in IDLE, so back-to-back operation is allowed.
- Invariant: a == quotient*b + remainder (mod 2^W), and |remainder| < |b|, for all b != 0.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE, ITER, FIX, DONE);
  - localparam CNT_W = $clog2(W+1);
  - function abs_w, which returns the magnitude as unsigned W bits.
- Sub-module div_step: combinational single restoring step.
  - Inputs: P, Q, |b|.
  - Outputs: next P, next Q.
  - Instanced once inside the ITER datapath.

Test Plan:
- a=150, b=10 -> quotient=15, remainder=0, done exactly 33 edges after accept (W=32), busy high for edges 1..32.
- a=-300, b=12 -> quotient=-25, remainder=0; a=-7, b=2 -> quotient=-3, remainder=-1; a=7, b=-2 -> quotient=-3, remainder=1.
- a=32'h80000000, b=32'hFFFFFFFF -> quotient=32'h80000000, remainder=0, div_by_zero=0; a=32'h7FFFFFFF, b=1 -> quotient=32'h7FFFFFFF, remainder=0.
- a=123, b=0 -> quotient=32'hFFFFFFFF, remainder=123, div_by_zero=1, done one edge after accept, busy stays 0.
- start a=100, b=7; re-pulse start with a=1, b=1 at edge 5 -> the second start is ignored and the result is quotient=14, remainder=2. Then a second start in DONE with a=9, b=3 -> done drops next edge and the result is 3 r 0.
- Start a=1000, b=3; drive rst_n low at edge 10 -> all outputs 0 immediately (asynchronous, before the next edge) and state IDLE. After release, a fresh start with a=-9, b=4 gives -2 r -1.
